// File: rtl/uart_mmio_ctrl.sv
// UART with memory-mapped TXD/RXD/CON registers, 8N1 framing, TX/RX interrupts.
// Latency: TX line drops 1 cycle after a TXD write; RX commits at mid stop bit (+2 sync flops).
// Backpressure: TXD writes while TX_BUSY are dropped; unread RX bytes are overwritten and flag OVERRUN.
module uart_mmio_ctrl #(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 9600
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        UART_rxd,
   output logic        UART_txd,
   output logic        irq
);

   localparam int DIV  = CLK_FREQ / BAUD;
   localparam int HALF = DIV / 2;
   localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

   localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
   localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
   localparam logic [31:0] ADDR_CON = 32'h4000_0020;

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

   // ---------------- bus decode ----------------
   logic w_sel_txd, w_sel_rxd, w_sel_con;
   logic w_rd_rxd, w_rd_con, w_wr_txd, w_wr_con;
   logic w_unused;

   assign w_sel_txd = (addr == ADDR_TXD);
   assign w_sel_rxd = (addr == ADDR_RXD);
   assign w_sel_con = (addr == ADDR_CON);
   assign w_rd_rxd  = rd_en & w_sel_rxd;
   assign w_rd_con  = rd_en & w_sel_con;
   assign w_wr_txd  = wr_en & w_sel_txd;
   assign w_wr_con  = wr_en & w_sel_con;
   assign w_unused  = ^wdata[31:8];

   // ---------------- TX ----------------
   state_t          r_tx_state, w_tx_next;
   logic [CW-1:0]   r_tx_cnt;
   logic [2:0]      r_tx_bit;
   logic [7:0]      r_txd;
   logic            w_tx_tick, w_tx_start, w_tx_end, w_tx_busy, w_txd_line;

   assign w_tx_tick  = (r_tx_cnt == DIV_LAST);
   assign w_tx_start = w_wr_txd & (r_tx_state == ST_IDLE);

   // TX state register
   always_ff @(posedge clk) begin
      if (reset) r_tx_state <= ST_IDLE;
      else       r_tx_state <= w_tx_next;
   end

   // TX next-state: every non-idle state lasts one bit period
   always_comb begin
      w_tx_next = r_tx_state;
      case (r_tx_state)
         ST_IDLE:  if (w_tx_start) w_tx_next = ST_START;
         ST_START: if (w_tx_tick) w_tx_next = ST_DATA;
         ST_DATA:  if (w_tx_tick && (r_tx_bit == 3'd7)) w_tx_next = ST_STOP;
         ST_STOP:  if (w_tx_tick) w_tx_next = ST_IDLE;
         default:  w_tx_next = ST_IDLE;
      endcase
   end

   // TX outputs: line level, busy, and end-of-frame pulse
   always_comb begin
      w_txd_line = 1'b1;
      w_tx_busy  = 1'b1;
      w_tx_end   = 1'b0;
      case (r_tx_state)
         ST_IDLE:  w_tx_busy  = 1'b0;
         ST_START: w_txd_line = 1'b0;
         ST_DATA:  w_txd_line = r_txd[r_tx_bit];
         ST_STOP:  w_tx_end   = w_tx_tick;
         default:  w_tx_busy  = 1'b0;
      endcase
   end

   // TX bit timer, bit index and byte register (loaded only when idle)
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tx_cnt <= '0;
         r_tx_bit <= 3'd0;
         r_txd    <= 8'd0;
      end else begin
         if (r_tx_state == ST_IDLE) begin
            r_tx_cnt <= '0;
            r_tx_bit <= 3'd0;
         end else if (w_tx_tick) begin
            r_tx_cnt <= '0;
            if (r_tx_state == ST_DATA) r_tx_bit <= r_tx_bit + 3'd1;
         end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
         end
         if (w_tx_start) r_txd <= wdata[7:0];
      end
   end

   // ---------------- RX ----------------
   state_t          r_rx_state, w_rx_next;
   logic [CW-1:0]   r_rx_cnt;
   logic [2:0]      r_rx_bit;
   logic [7:0]      r_rx_shift, r_rxd;
   logic            r_rx_meta, r_rx_sync, r_rx_prev;
   logic            w_rx_fall, w_rx_half, w_rx_full;
   logic            w_rx_sample, w_rx_commit, w_rx_ferr;

   // Two-flop synchronizer plus one history flop for edge detection; idles high
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= UART_rxd;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   assign w_rx_fall = r_rx_prev & ~r_rx_sync;
   assign w_rx_half = (r_rx_cnt == HALF_LAST);
   assign w_rx_full = (r_rx_cnt == DIV_LAST);

   // RX state register
   always_ff @(posedge clk) begin
      if (reset) r_rx_state <= ST_IDLE;
      else       r_rx_state <= w_rx_next;
   end

   // RX next-state: half-bit start check rejects glitches, then whole-bit sampling
   always_comb begin
      w_rx_next = r_rx_state;
      case (r_rx_state)
         ST_IDLE:  if (w_rx_fall) w_rx_next = ST_START;
         ST_START: if (w_rx_half) w_rx_next = r_rx_sync ? ST_IDLE : ST_DATA;
         ST_DATA:  if (w_rx_full && (r_rx_bit == 3'd7)) w_rx_next = ST_STOP;
         ST_STOP:  if (w_rx_full) w_rx_next = ST_IDLE;
         default:  w_rx_next = ST_IDLE;
      endcase
   end

   // RX outputs: data sample strobe and stop-bit verdict
   always_comb begin
      w_rx_sample = 1'b0;
      w_rx_commit = 1'b0;
      w_rx_ferr   = 1'b0;
      case (r_rx_state)
         ST_DATA: w_rx_sample = w_rx_full;
         ST_STOP: begin
            w_rx_commit = w_rx_full & r_rx_sync;
            w_rx_ferr   = w_rx_full & ~r_rx_sync;
         end
         default: w_rx_sample = 1'b0;
      endcase
   end

   // RX bit timer, shift register and received byte
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_cnt   <= '0;
         r_rx_bit   <= 3'd0;
         r_rx_shift <= 8'd0;
         r_rxd      <= 8'd0;
      end else begin
         if ((r_rx_state == ST_IDLE) || ((r_rx_state == ST_START) && w_rx_half) || w_rx_full)
            r_rx_cnt <= '0;
         else
            r_rx_cnt <= r_rx_cnt + CW'(1);
         if (r_rx_state == ST_IDLE) r_rx_bit <= 3'd0;
         else if (w_rx_sample)      r_rx_bit <= r_rx_bit + 3'd1;
         if (w_rx_sample) r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
         if (w_rx_commit) r_rxd <= r_rx_shift;
      end
   end

   // ---------------- CON register ----------------
   logic r_txie, r_rxie, r_tx_done, r_rx_valid, r_overrun, r_frame_err;
   logic [31:0] w_con;

   // Enables are RW; status flags set on events, clear on read, set wins
   always_ff @(posedge clk) begin
      if (reset) begin
         r_txie      <= 1'b0;
         r_rxie      <= 1'b0;
         r_tx_done   <= 1'b0;
         r_rx_valid  <= 1'b0;
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         if (w_wr_con) begin
            r_txie <= wdata[0];
            r_rxie <= wdata[1];
         end
         if (w_tx_end)                      r_tx_done   <= 1'b1;
         else if (w_rd_con)                 r_tx_done   <= 1'b0;
         if (w_rx_ferr)                     r_frame_err <= 1'b1;
         else if (w_rd_con)                 r_frame_err <= 1'b0;
         if (w_rx_commit)                   r_rx_valid  <= 1'b1;
         else if (w_rd_rxd)                 r_rx_valid  <= 1'b0;
         if (w_rx_commit && r_rx_valid)     r_overrun   <= 1'b1;
         else if (w_rd_rxd)                 r_overrun   <= 1'b0;
      end
   end

   assign w_con = {25'd0, r_frame_err, r_overrun, w_tx_busy, r_rx_valid,
                   r_tx_done, r_rxie, r_txie};

   // Combinational read mux; zero when idle or unmapped
   always_comb begin
      rdata = 32'd0;
      if (rd_en) begin
         if (w_sel_txd)      rdata = {24'd0, r_txd};
         else if (w_sel_rxd) rdata = {24'd0, r_rxd};
         else if (w_sel_con) rdata = w_con;
      end
   end

   assign UART_txd = w_txd_line;
   assign irq      = (r_txie & r_tx_done) | (r_rxie & r_rx_valid);

endmodule
